// File: rtl/sram_mem_controller.sv
// sram_mem_controller: 32-bit MEM-stage load/store over a 16-bit async SRAM.
// Optional statistics counters are enabled by defining SRAM_CTRL_STATS_EN.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic [31:0]        read_count,
    output logic [31:0]        write_count,
    output logic [31:0]        stall_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic [SRAM_AW-2:0] word_idx;
    logic               last;

    // Word index wraps modulo the SRAM size; out-of-range is not flagged.
    assign word_idx = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
    assign last     = (cnt == LAST);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and SRAM strobe decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state)
            IDLE: begin
                ready = ~(wr_en | rd_en);
                if (wr_en) begin
                    state_nxt = WR_LO;
                    cnt_nxt   = '0;
                end else if (rd_en) begin
                    state_nxt = RD_LO;
                    cnt_nxt   = '0;
                end
            end
            RD_LO, RD_HI: begin
                sram_addr = {word_idx, state == RD_HI};
                if (last) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == RD_LO) ? RD_HI : DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            WR_LO, WR_HI: begin
                sram_addr   = {word_idx, state == WR_HI};
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == WR_HI) ? write_data[31:16]
                                               : write_data[15:0];
                // Strobe rises one cycle early so data is held past WE.
                sram_we_n   = last;
                if (last) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == WR_LO) ? WR_HI : DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture each read half on the last cycle of its access.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (last) begin
            if (state == RD_LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == RD_HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    logic        op_wr;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] stall_q;

    // Remember the operation type and count completions and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            if (state == IDLE) begin
                op_wr <= wr_en;
            end
            if (state == DONE) begin
                if (op_wr) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                end
            end
            if (!ready) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign read_count   = rd_cnt_q;
    assign write_count  = wr_cnt_q;
    assign stall_cycles = stall_q;
`else
    assign read_count   = '0;
    assign write_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: randomized bench with an SRAM model and a
// word-level reference memory for sram_mem_controller.
module tb_sram_mem_controller;

    localparam int W    = 3;
    localparam int BASE = 1024;
    localparam int AW   = 18;
    localparam int LOWN = 1 + 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic [31:0]   read_count;
    logic [31:0]   write_count;
    logic [31:0]   stall_cycles;

    int tests = 0;
    int fails = 0;

    logic [15:0]   sram [0:(1<<AW)-1];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [15:0]   poke_data = '0;

    logic [31:0]   ref_mem [0:63];
    logic [31:0]   ref_rd;

    logic [AW-1:0] tr_addr [LOWN];
    logic          tr_wen  [LOWN];
    logic          tr_oe   [LOWN];
    logic [15:0]   tr_dout [LOWN];
    int            low_cnt;
    bit            done_ok;

    sram_mem_controller #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE),
        .SRAM_AW    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .read_count  (read_count),
        .write_count (write_count),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write while WE is low.
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (poke_en) begin
            sram[poke_addr] <= poke_data;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram[sram_addr] <= sram_dq_out;
        end
    end

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'(BASE);
        return int'((off >> 2) % (32'd1 << (AW - 1)));
    endfunction

    task automatic poke(input int w, input logic [31:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = AW'(2 * w);
        poke_data = v[15:0];
        @(negedge clk);
        poke_addr = AW'(2 * w + 1);
        poke_data = v[31:16];
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[w] = v;
    endtask

    // Issue one request at the next edge and trace every low-ready cycle.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        @(posedge clk);
        #1;
        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = d;
        low_cnt    = 0;
        done_ok    = 0;
        @(negedge clk);
        for (int g = 0; g < 40; g++) begin
            #1;
            if (ready) begin
                done_ok = 1;
                break;
            end
            if (low_cnt < LOWN) begin
                tr_addr[low_cnt] = sram_addr;
                tr_wen[low_cnt]  = sram_we_n;
                tr_oe[low_cnt]   = sram_dq_oe;
                tr_dout[low_cnt] = sram_dq_out;
            end
            low_cnt++;
            @(negedge clk);
        end
        if (!hold) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
            sram_addr !== '0 || read_data !== '0) begin
            fails++;
            $display("FAIL reset: rdy=%b we_n=%b oe=%b addr=%h rd=%h",
                     ready, sram_we_n, sram_dq_oe, sram_addr, read_data);
        end
        tests++;
        if ({read_count, write_count, stall_cycles} !== '0) begin
            fails++;
            $display("FAIL reset_counters: got %h %h %h want 0",
                     read_count, write_count, stall_cycles);
        end
        rst = 1'b0;
        ref_rd = '0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 ||
                sram_dq_oe !== 1'b0) begin
                fails++;
                $display("FAIL idle: rdy=%b we_n=%b oe=%b want 1 1 0",
                         ready, sram_we_n, sram_dq_oe);
            end
        end
    endtask

    task automatic test_read;
        poke(0, 32'hABCD_1234);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        tests++;
        if (!done_ok || low_cnt != LOWN) begin
            fails++;
            $display("FAIL read_latency: low=%0d done=%0d want %0d",
                     low_cnt, done_ok, LOWN);
        end
        for (int i = 1; i < LOWN; i++) begin
            tests++;
            if (tr_addr[i] !== AW'((i - 1) / W) || tr_wen[i] !== 1'b1 ||
                tr_oe[i] !== 1'b0) begin
                fails++;
                $display("FAIL read_trace[%0d]: addr=%0d we_n=%b oe=%b",
                         i, tr_addr[i], tr_wen[i], tr_oe[i]);
            end
        end
        ref_rd = 32'hABCD_1234;
        tests++;
        if (read_data !== ref_rd) begin
            fails++;
            $display("FAIL read_data: got %h want %h", read_data, ref_rd);
        end
    endtask

    task automatic test_write;
        access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0);
        tests++;
        if (!done_ok || low_cnt != LOWN) begin
            fails++;
            $display("FAIL write_latency: low=%0d done=%0d want %0d",
                     low_cnt, done_ok, LOWN);
        end
        for (int i = 1; i < LOWN; i++) begin
            tests++;
            if (tr_wen[i] !== (((i - 1) % W) == W - 1) ||
                tr_oe[i] !== 1'b1 ||
                tr_addr[i] !== AW'(2 + (i - 1) / W)) begin
                fails++;
                $display("FAIL write_trace[%0d]: we_n=%b oe=%b addr=%0d",
                         i, tr_wen[i], tr_oe[i], tr_addr[i]);
            end
        end
        @(negedge clk);
        tests++;
        if (sram[2] !== 16'hBEEF || sram[3] !== 16'hDEAD) begin
            fails++;
            $display("FAIL write_mem: got %h %h want dead beef",
                     sram[3], sram[2]);
        end
        tests++;
        if (read_data !== ref_rd) begin
            fails++;
            $display("FAIL write_keeps_rd: got %h want %h", read_data, ref_rd);
        end
    endtask

    task automatic test_both;
        access(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        tests++;
        if (!done_ok || sram[4] !== 16'hF00D || sram[5] !== 16'h0BAD ||
            read_data !== ref_rd) begin
            fails++;
            $display("FAIL both_priority: mem=%h%h rd=%h want 0badf00d %h",
                     sram[5], sram[4], read_data, ref_rd);
        end
    endtask

    task automatic test_back_to_back;
        int total;
        poke(6, 32'h5566_7788);
        access(1'b0, 1'b1, 32'd1048, 32'h0, 1'b1);
        total = low_cnt + (done_ok ? 1 : 0);
        tests++;
        if (!done_ok || low_cnt != LOWN || read_data !== 32'h5566_7788) begin
            fails++;
            $display("FAIL b2b_first: low=%0d rd=%h want %0d 55667788",
                     low_cnt, read_data, LOWN);
        end
        ref_rd = 32'h5566_7788;
        access(1'b1, 1'b0, 32'd1052, 32'h1357_9BDF, 1'b0);
        total += low_cnt + (done_ok ? 1 : 0);
        tests++;
        if (!done_ok || low_cnt != LOWN || total != 16) begin
            fails++;
            $display("FAIL b2b_second: low=%0d total=%0d want %0d 16",
                     low_cnt, total, LOWN);
        end
        @(negedge clk);
        tests++;
        if (sram[14] !== 16'h9BDF || sram[15] !== 16'h1357) begin
            fails++;
            $display("FAIL b2b_mem: got %h%h want 13579bdf",
                     sram[15], sram[14]);
        end
    endtask

    task automatic test_random;
        for (int w = 0; w < 64; w++) begin
            poke(w, $urandom);
        end
        for (int n = 0; n < 30; n++) begin
            int          w;
            int          k;
            int          op;
            bit          wr;
            logic [31:0] a;
            logic [31:0] d;
            w  = int'($urandom_range(0, 63));
            k  = int'($urandom_range(0, 3));
            op = int'($urandom_range(0, 2));
            wr = (op != 0);
            d  = $urandom;
            a  = 32'(BASE) + 32'(4 * w);
            if (k == 1) a = a + (32'd4 << (AW - 1));
            if (k == 2) a = a - (32'd4 << (AW - 1));
            if (k == 3) a = a + (32'd4 << (AW - 1)) * $urandom_range(1, 99);
            access(wr, op != 1, a, d, 1'b0);
            tests++;
            if (!done_ok || low_cnt != LOWN) begin
                fails++;
                $display("FAIL rand_latency[%0d]: low=%0d want %0d",
                         n, low_cnt, LOWN);
            end
            for (int i = 1; i < LOWN; i++) begin
                int   half;
                logic ew;
                half = (i - 1) / W;
                ew   = wr ? (((i - 1) % W) == W - 1) : 1'b1;
                tests++;
                if (tr_addr[i] !== AW'(2 * word_of(a) + half) ||
                    tr_wen[i] !== ew || tr_oe[i] !== wr ||
                    tr_dout[i] !== (wr ? (half ? d[31:16] : d[15:0])
                                       : 16'h0)) begin
                    fails++;
                    $display("FAIL rand_trace[%0d.%0d]: addr=%0d we_n=%b",
                             n, i, tr_addr[i], tr_wen[i]);
                end
            end
            if (wr) begin
                ref_mem[w] = d;
            end else begin
                ref_rd = ref_mem[w];
            end
            tests++;
            if (read_data !== ref_rd) begin
                fails++;
                $display("FAIL rand_rd[%0d]: got %h want %h",
                         n, read_data, ref_rd);
            end
            @(negedge clk);
            tests++;
            if ({sram[2*w+1], sram[2*w]} !== ref_mem[w]) begin
                fails++;
                $display("FAIL rand_mem[%0d]: got %h%h want %h",
                         n, sram[2*w+1], sram[2*w], ref_mem[w]);
            end
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #1;
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'(BASE + 400);
        write_data = 32'hCAFE_D00D;
        repeat (LOWN - 1) @(negedge clk);
        #1;
        tests++;
        if (sram_addr !== AW'(201) || sram_we_n !== 1'b0) begin
            fails++;
            $display("FAIL mid_phase: addr=%0d we_n=%b want 201 0",
                     sram_addr, sram_we_n);
        end
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
            read_data !== '0 || sram_addr !== '0) begin
            fails++;
            $display("FAIL mid_reset: rdy=%b we_n=%b oe=%b rd=%h addr=%0d",
                     ready, sram_we_n, sram_dq_oe, read_data, sram_addr);
        end
        rst    = 1'b0;
        ref_rd = '0;
    endtask

    task automatic test_stats;
        logic [31:0] erc;
        logic [31:0] ewc;
        logic [31:0] esc;
        access(1'b0, 1'b1, 32'(BASE + 8), 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'(BASE + 12), 32'h2468_ACE0, 1'b0);
        access(1'b0, 1'b1, 32'(BASE + 16), 32'h0, 1'b0);
        @(negedge clk);
`ifdef SRAM_CTRL_STATS_EN
        erc = 32'd2;
        ewc = 32'd1;
        esc = 32'(3 * (1 + 2 * W));
`else
        erc = '0;
        ewc = '0;
        esc = '0;
`endif
        tests++;
        if (read_count !== erc || write_count !== ewc ||
            stall_cycles !== esc) begin
            fails++;
            $display("FAIL stats: got %0d %0d %0d want %0d %0d %0d",
                     read_count, write_count, stall_cycles, erc, ewc, esc);
        end
        tests++;
        if (read_data !== ref_mem[4]) begin
            fails++;
            $display("FAIL stats_rd: got %h want %h", read_data, ref_mem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read();
        test_write();
        test_both();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM stage of the 5-stage ARM pipeline and an external 16-bit asynchronous SRAM.
- Converts each 32-bit pipeline load/store into two 16-bit SRAM accesses with programmable wait states.
- Drives `ready`; the top level uses ~ready as the pipeline freeze for IF_Reg/ID_Reg/EXE_Reg/MEM_Reg and IF_Stage. Requests are therefore held stable while ready=0.

Parameters:
- WAIT_CYCLES, 3: cycles per 16-bit SRAM access; legal range 2..15.
- BASE_ADDR, 1024: byte address of the first data-memory word.
- SRAM_AW, 18: SRAM address width (16-bit words).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  store request from MEM stage.
- rd_en  input  1  load request from MEM stage.
- address  input  32  byte address (ALU result); word-aligned.
- write_data  input  32  store value.
- read_data  output  32  load result; valid while ready=1 after a read.
- ready  output  1  0 = pipeline must freeze.
- sram_addr  output  SRAM_AW  SRAM word address.
- sram_dq_out  output  16  write data to SRAM.
- sram_dq_in  input  16  read data from SRAM.
- sram_dq_oe  output  1  1 = controller drives DQ.
- sram_we_n  output  1  active-low SRAM write strobe.
- read_count  output  32  completed reads (feature).
- write_count  output  32  completed writes (feature).
- stall_cycles  output  32  cycles with ready=0 (feature).

Behaviour:
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A 4-bit wait counter `cnt` is used in the four access states.
- Word index: w = (address − BASE_ADDR) >> 2, truncated to SRAM_AW−1 bits.
  - LO accesses sram_addr = {w, 1'b0} (bits 15:0).
  - HI accesses sram_addr = {w, 1'b1} (bits 31:16).
- IDLE:
  - wr_en=1 → WR_LO, cnt=0. wr_en takes priority if rd_en is also 1.
  - else rd_en=1 → RD_LO, cnt=0.
  - else stay in IDLE.
  - ready = ~(wr_en | rd_en). This is combinational, so freeze takes effect in the request cycle.
- Access states:
  - Stay while cnt < WAIT_CYCLES−1, incrementing cnt.
  - At cnt == WAIT_CYCLES−1: LO → HI with cnt=0; HI → DONE.
  - ready=0 throughout.
- RD_LO/RD_HI:
  - sram_dq_oe=0, sram_we_n=1.
  - read_data[15:0] (RD_LO) or read_data[31:16] (RD_HI) is registered from sram_dq_in on the last cycle.
- WR_LO/WR_HI:
  - sram_dq_oe=1.
  - sram_dq_out = write_data[15:0] (WR_LO) or write_data[31:16] (WR_HI).
  - sram_we_n=0 for cnt < WAIT_CYCLES−1 and 1 on the last cycle (data hold).
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances on this edge.
  - Unconditional return to IDLE. A new request is evaluated there the following cycle.
- Latency: ready is low for 1 + 2·WAIT_CYCLES cycles per access, then high in DONE. With WAIT_CYCLES=3 that is 7 low cycles and 1 high cycle.
- read_data holds its last value until overwritten by the next read. Writes do not modify it.
- Outside WR states: sram_dq_oe=0, sram_we_n=1, sram_dq_out=0.
- Reset (any state, including mid-access):
  - state IDLE, cnt=0, read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, all counters 0.
  - ready follows the IDLE rule.
  - An interrupted write may leave the SRAM half-written; this is accepted.
- Address outside the SRAM range wraps modulo 2^(SRAM_AW−1) words; no error flag is raised.

Optional Feature:
- Macro: SRAM_CTRL_STATS_EN.
- Defined:
  - read_count increments on each DONE following a read.
  - write_count increments on each DONE following a write.
  - stall_cycles increments every cycle ready=0.
  - All three wrap at 2^32 and are cleared by rst.
- Undefined: the three ports exist but are tied to 0, and no counter flops are synthesized.

Test Plan:
- Idle, no request, WAIT_CYCLES=3 → ready=1; sram_we_n=1; sram_dq_oe=0; state stays IDLE.
- Read at address 1024, SRAM model word0=0x1234 and word1=0xABCD → sram_addr 0 for 3 cycles, then 1 for 3 cycles; ready low 7 cycles; read_data=0xABCD1234 in DONE.
- Write 0xDEADBEEF at address 1028 → addr 2 gets 0xBEEF, addr 3 gets 0xDEAD; sram_we_n low 2 of 3 cycles per half; ready low 7 cycles; read_data unchanged.
- rd_en=1 and wr_en=1 together at 1032 → write performed (addr 4/5 written); no read_data update.
- Back-to-back read then write, request held low-to-high across DONE → second access starts in the cycle after DONE; 16 total cycles; ready pattern 0×7, 1, 0×7, 1.
- rst asserted in WR_HI cnt=1 → next cycle IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0. With SRAM_CTRL_STATS_EN defined, after 2 reads and 1 write: read_count=2, write_count=1, stall_cycles=21.
